// File: rtl/conv_ibuf_ctrl.sv
// Input-buffer controller for a bit-serial CIM convolution: loads pixels in raster
// order and, once a full KxK window is present, streams DATA_SIZE*NUM_ADDR beats to the tiles.
module conv_ibuf_ctrl #(
  parameter int DATA_SIZE      = 8,
  parameter int IMG_DIM        = 28,
  parameter int KERNEL_DIM     = 3,
  parameter int INPUT_CHANNELS = 2,
  parameter int XBAR_SIZE      = 128,
  parameter int BUS_WIDTH      = 16,
  localparam int WIN_ELEMS     = INPUT_CHANNELS * KERNEL_DIM * KERNEL_DIM,
  localparam int V_TILES       = (WIN_ELEMS + XBAR_SIZE - 1) / XBAR_SIZE,
  localparam int NUM_ADDR_RAW  = (WIN_ELEMS + BUS_WIDTH * V_TILES - 1) / (BUS_WIDTH * V_TILES),
  localparam int NUM_ADDR      = (NUM_ADDR_RAW < 1) ? 1 : NUM_ADDR_RAW,
  localparam int COUNT_WIDTH   = (DATA_SIZE == 1) ? 1 : $clog2(DATA_SIZE),
  localparam int ADDR_WIDTH    = (NUM_ADDR <= 1) ? 1 : $clog2(NUM_ADDR)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [INPUT_CHANNELS-1:0] o_write_enable,
  output logic [COUNT_WIDTH-1:0]    o_count,
  output logic [ADDR_WIDTH-1:0]     o_ibuf_addr,
  output logic                      o_cim_valid,
  input  logic                      i_cim_ready,
  output logic                      o_last,
  output logic                      o_done,
  output logic                      o_dbg_state
);

  // Handshakes: a pixel moves when i_valid && o_ready; a beat moves when
  // o_cim_valid && i_cim_ready. Neither valid waits on its ready.

  localparam int POS_WIDTH = (IMG_DIM <= 1) ? 1 : $clog2(IMG_DIM);
  localparam logic [POS_WIDTH-1:0]   POS_MAX   = POS_WIDTH'(IMG_DIM - 1);
  localparam logic [POS_WIDTH-1:0]   WIN_MIN   = POS_WIDTH'(KERNEL_DIM - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(DATA_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_MAX  = ADDR_WIDTH'(NUM_ADDR - 1);

  typedef enum logic {LOAD = 1'b0, SEND = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [POS_WIDTH-1:0]   r_row;
  logic [POS_WIDTH-1:0]   r_col;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_final;
  logic                   r_done;
  logic                   w_accept;
  logic                   w_trigger;
  logic                   w_beat_hs;
  logic                   w_addr_wrap;
  logic                   w_last;

  assign w_addr_wrap    = (r_addr == ADDR_MAX);
  assign w_last         = (r_count == COUNT_MAX) && w_addr_wrap;
  assign o_last         = (r_state == SEND) && w_last;
  assign o_count        = r_count;
  assign o_ibuf_addr    = r_addr;
  assign o_done         = r_done;
  assign o_write_enable = {INPUT_CHANNELS{w_accept}};
  assign o_dbg_state    = (r_state == SEND);

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_ready      = 1'b0;
    o_cim_valid  = 1'b0;
    w_accept     = 1'b0;
    w_trigger    = 1'b0;
    w_beat_hs    = 1'b0;
    case (r_state)
      LOAD: begin
        o_ready   = !rst;
        w_accept  = i_valid && !rst;
        w_trigger = w_accept && (r_row >= WIN_MIN) && (r_col >= WIN_MIN);
        if (w_trigger) w_next_state = SEND;
      end
      SEND: begin
        o_cim_valid = 1'b1;
        w_beat_hs   = i_cim_ready;
        if (w_beat_hs && w_last) w_next_state = LOAD;
      end
      default: w_next_state = LOAD;
    endcase
  end

  // The final pixel wraps row/col straight away; r_final remembers it so the
  // done pulse lines up with the end of that pixel's window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_final <= 1'b0;
    end else if (w_accept) begin
      if (r_col == POS_MAX) begin
        r_col <= '0;
        r_row <= (r_row == POS_MAX) ? '0 : r_row + POS_WIDTH'(1);
      end else begin
        r_col <= r_col + POS_WIDTH'(1);
      end
      if (w_trigger) r_final <= (r_row == POS_MAX) && (r_col == POS_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_trigger) begin
        r_count <= '0;
        r_addr  <= '0;
      end else if (w_beat_hs) begin
        if (w_last) begin
          r_count <= '0;
          r_addr  <= '0;
          r_done  <= r_final;
        end else if (w_addr_wrap) begin
          r_addr  <= '0;
          r_count <= r_count + COUNT_WIDTH'(1);
        end else begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_ibuf_ctrl.sv
// Directed bench for conv_ibuf_ctrl on a 4x4 image, 3x3 kernel, 2 channels, 2-bit pixels
// (2 bus words, 4 beats per window; windows triggered by pixels 10, 11, 14, 15).
module tb_conv_ibuf_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [1:0] o_write_enable;
  logic       o_count;
  logic       o_ibuf_addr;
  logic       o_cim_valid;
  logic       i_cim_ready;
  logic       o_last;
  logic       o_done;
  logic       o_dbg_state;

  conv_ibuf_ctrl #(
    .DATA_SIZE(2), .IMG_DIM(4), .KERNEL_DIM(3),
    .INPUT_CHANNELS(2), .XBAR_SIZE(128), .BUS_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .o_write_enable(o_write_enable), .o_count(o_count), .o_ibuf_addr(o_ibuf_addr),
    .o_cim_valid(o_cim_valid), .i_cim_ready(i_cim_ready), .o_last(o_last),
    .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          acc_cnt, win_cnt, done_cnt, beat_idx;
  logic        prev_cv, prev_last_hs;
  bit          mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready", 32'(o_ready), 32'(!o_cim_valid && !rst));
      check("write_en", 32'(o_write_enable), (i_valid && !o_cim_valid && !rst) ? 32'd3 : 32'd0);
      if (!o_cim_valid) check("last_idle", 32'(o_last), 32'd0);
      if (o_cim_valid && !prev_cv) begin
        win_cnt++;
        if (exp_q.size() == 0) check("trig_extra", 32'(acc_cnt - 1), 32'hffff_ffff);
        else                   check("trig_pixel", 32'((acc_cnt - 1) % 16), exp_q.pop_front());
        beat_idx = 0;
      end
      if (o_done) begin
        done_cnt++;
        check("done_after_last", 32'(prev_last_hs), 32'd1);
        check("done_win", 32'(win_cnt % 4), 32'd0);
      end
      prev_last_hs = o_cim_valid && i_cim_ready && o_last;
      if (o_cim_valid && i_cim_ready) begin
        check("beat_count", 32'(o_count), 32'(beat_idx / 2));
        check("beat_addr", 32'(o_ibuf_addr), 32'(beat_idx % 2));
        check("beat_last", 32'(o_last), 32'(beat_idx == 3));
        beat_idx++;
      end
      if (o_write_enable != 2'b00) acc_cnt++;
      prev_cv = o_cim_valid;
    end
  end

  // driver tasks
  task automatic clear_sb();
    acc_cnt = 0; win_cnt = 0; done_cnt = 0; beat_idx = 0;
    prev_cv = 1'b0; prev_last_hs = 1'b0;
    exp_q.delete();
  endtask

  task automatic expect_image();
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd11);
    exp_q.push_back(32'd14);
    exp_q.push_back(32'd15);
  endtask

  task automatic send_pixels(input int npix, input bit gaps);
    int cyc = 0;
    bit tog = 1'b1;
    while (acc_cnt < npix && cyc < 1000) begin
      i_valid = gaps ? tog : 1'b1;
      tog = !tog;
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    check("pixel_timeout", 32'(acc_cnt), 32'(npix));
  endtask

  task automatic wait_done(input int ndone);
    int cyc = 0;
    while (done_cnt < ndone && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_timeout", 32'(done_cnt), 32'(ndone));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic end_test(input string tag, input int nwin, input int ndone);
    check({tag, "_windows"}, 32'(win_cnt), 32'(nwin));
    check({tag, "_dones"}, 32'(done_cnt), 32'(ndone));
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; i_valid = 1'b1; i_cim_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_we", 32'(o_write_enable), 32'd0);
    check("rst_cim_valid", 32'(o_cim_valid), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_addr", 32'(o_ibuf_addr), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    rst = 1'b0; i_valid = 1'b0; i_cim_ready = 1'b1;
    clear_sb();
    mon_en = 1'b1;
    #1;
    check("idle_ready", 32'(o_ready), 32'd1);

    // full stream, no stalls
    @(posedge clk); #1;
    clear_sb(); expect_image();
    send_pixels(16, 1'b0);
    wait_done(1);
    end_test("stream", 4, 1);

    // upstream gaps
    clear_sb(); expect_image();
    send_pixels(16, 1'b1);
    wait_done(1);
    end_test("gaps", 4, 1);

    // downstream backpressure at beat (0,1)
    clear_sb(); expect_image();
    i_valid = 1'b1;
    cyc = 0;
    while (!o_cim_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_window_start", 32'(o_cim_valid), 32'd1);
    @(posedge clk); #1;
    i_cim_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_count", 32'(o_count), 32'd0);
      check("bp_addr", 32'(o_ibuf_addr), 32'd1);
      check("bp_cim_valid", 32'(o_cim_valid), 32'd1);
      check("bp_ready", 32'(o_ready), 32'd0);
      @(posedge clk); #1;
    end
    i_cim_ready = 1'b1;
    send_pixels(16, 1'b0);
    wait_done(1);
    end_test("bp", 4, 1);

    // reset during beat (1,0) of window 2
    clear_sb(); expect_image();
    i_valid = 1'b1;
    cyc = 0;
    while (!(win_cnt == 2 && o_cim_valid && o_count == 1'b1 && o_ibuf_addr == 1'b0) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mrst_reach", 32'(win_cnt), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_cim_valid", 32'(o_cim_valid), 32'd0);
    check("mrst_state", 32'(o_dbg_state), 32'd0);
    check("mrst_ready", 32'(o_ready), 32'd0);
    check("mrst_we", 32'(o_write_enable), 32'd0);
    check("mrst_last", 32'(o_last), 32'd0);
    check("mrst_done", 32'(o_done), 32'd0);
    check("mrst_count", 32'(o_count), 32'd0);
    check("mrst_addr", 32'(o_ibuf_addr), 32'd0);
    check("mrst_row", 32'(dut.r_row), 32'd0);
    check("mrst_col", 32'(dut.r_col), 32'd0);
    clear_sb();
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    clear_sb(); expect_image();
    send_pixels(16, 1'b0);
    wait_done(1);
    end_test("mrst", 4, 1);

    // two images back to back
    clear_sb(); expect_image(); expect_image();
    send_pixels(32, 1'b0);
    wait_done(2);
    end_test("b2b", 8, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_ibuf_ctrl.md
CONV_IBUF_CTRL -- requirements
Module: conv_ibuf_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, pixel bit width (number of bit-serial slices).
REQ-002 SHALL have parameter IMG_DIM, default 28, square input image side.
REQ-003 SHALL have parameter KERNEL_DIM, default 3, square kernel side; stride 1, no padding.
REQ-004 SHALL have parameter INPUT_CHANNELS, default 2, channels written in lockstep.
REQ-005 SHALL have parameters XBAR_SIZE, default 128, and BUS_WIDTH, default 16, crossbar rows and bus bits per tile.
REQ-006 SHALL derive the following localparams:
- V_TILES = ceil(INPUT_CHANNELS*KERNEL_DIM^2 / XBAR_SIZE).
- NUM_ADDR = max(1, ceil(INPUT_CHANNELS*KERNEL_DIM^2 / (BUS_WIDTH*V_TILES))).
- COUNT_WIDTH = 1 if DATA_SIZE==1, else clog2(DATA_SIZE).
- ADDR_WIDTH = 1 if NUM_ADDR<=1, else clog2(NUM_ADDR).
REQ-007 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port i_valid, input, 1 bit: upstream pixel (all channels) present.
REQ-010 SHALL have port o_ready, output, 1 bit: block accepts a pixel this cycle.
REQ-011 SHALL have port o_write_enable, output, INPUT_CHANNELS bits: shift enable to the input buffer FIFOs.
REQ-012 SHALL have port o_count, output, COUNT_WIDTH bits: bit-slice select to the input buffer.
REQ-013 SHALL have port o_ibuf_addr, output, ADDR_WIDTH bits: bus-word select to the input buffer.
REQ-014 SHALL have port o_cim_valid, output, 1 bit: current (o_count, o_ibuf_addr) beat is valid for the CIM tiles.
REQ-015 SHALL have port i_cim_ready, input, 1 bit: CIM tiles consume the beat.
REQ-016 SHALL have port o_last, output, 1 bit: current beat is the final beat of a window.
REQ-017 SHALL have port o_done, output, 1 bit: one-cycle pulse after the last window of an image.

Function
REQ-018 SHALL implement FSM states LOAD and SEND.
REQ-019 SHALL drive o_ready=1 only in LOAD.
REQ-020 SHALL drive o_write_enable = all ones when i_valid && o_ready, else all zeros (combinational).
REQ-021 SHALL keep pixel counters row, col in [0, IMG_DIM-1], raster order: col increments per accepted pixel, wraps to 0 at IMG_DIM-1 with row+1.
REQ-022 SHALL transition LOAD->SEND on an accepted pixel with row>=KERNEL_DIM-1 and col>=KERNEL_DIM-1; otherwise stay in LOAD.
REQ-023 SHALL clear o_count and o_ibuf_addr to 0 on entry to SEND.
REQ-024 SHALL in SEND drive o_cim_valid=1 and hold o_count and o_ibuf_addr stable until i_cim_ready.
REQ-025 SHALL on each handshake (o_cim_valid && i_cim_ready) advance the beat as follows:
- o_ibuf_addr increments first.
- At NUM_ADDR-1, o_ibuf_addr wraps to 0 and o_count increments.
REQ-026 SHALL assert o_last when o_count==DATA_SIZE-1 and o_ibuf_addr==NUM_ADDR-1 in SEND.
REQ-027 SHALL on handshake with o_last return to LOAD the next cycle, clearing o_count and o_ibuf_addr to 0.
REQ-028 SHALL make each window exactly DATA_SIZE*NUM_ADDR beats; minimum window period is that count plus 1 load cycle.
REQ-029 SHALL, if the window was triggered by pixel (IMG_DIM-1, IMG_DIM-1):
- pulse o_done for one cycle coincident with the LOAD re-entry.
- reset row and col to 0.
REQ-030 SHALL accept no pixels while in SEND; upstream stalls via o_ready=0.
REQ-031 SHALL drive o_cim_valid=0 and o_last=0 in LOAD.
REQ-032 SHALL produce (IMG_DIM-KERNEL_DIM+1)^2 windows per image.

Reset
REQ-033 SHALL on rst force the following the next edge, regardless of state (including mid-SEND):
- state=LOAD, row=col=0, o_count=0, o_ibuf_addr=0.
- o_cim_valid=0, o_last=0, o_done=0.
REQ-034 SHALL drive o_ready=0 and o_write_enable=0 while rst is high.

Verification (IMG_DIM=4, KERNEL_DIM=3, INPUT_CHANNELS=2, DATA_SIZE=2, BUS_WIDTH=16, XBAR_SIZE=128 -> NUM_ADDR=2, 4 beats/window)
REQ-035 SHALL verify the full stream:
- Stimulus: i_valid=1 and i_cim_ready=1 constantly.
- Response: exactly 4 windows, triggered by pixels 10, 11, 14 and 15.
- Beat sequence per window: (count,addr) = (0,0),(0,1),(1,0),(1,1), with o_last on (1,1).
- o_done pulses once after the 4th window.
REQ-036 SHALL verify backpressure: hold i_cim_ready=0 for 5 cycles at beat (0,1) -> o_count and o_ibuf_addr stay at (0,1), o_cim_valid stays 1, o_ready stays 0.
REQ-037 SHALL verify upstream gaps: toggle i_valid every other cycle -> o_write_enable=2'b11 only on accepted cycles, and window triggers stay at pixels 10, 11, 14 and 15.
REQ-038 SHALL verify reset mid-SEND: assert rst during beat (1,0) of window 2 -> next cycle LOAD, o_cim_valid=0, row=col=0; a fresh image then yields 4 windows.
REQ-039 SHALL verify back-to-back images: send 32 pixels without gaps -> 8 windows and 2 o_done pulses, with the 2nd image's windows triggered at its pixels 10, 11, 14 and 15.
